// File: rtl/board_io_cond.sv
// Board-edge I/O conditioner: per-channel key polarity, two-flop sync, debounce,
// press/release pulses and registered LED drive. Optional auto-repeat: BOARD_IO_AUTOREPEAT_EN.
module board_io_cond #(
  parameter int                 KEYS_W       = 4,
  parameter int                 LEDS_W       = 8,
  parameter logic [KEYS_W-1:0]  KEY_INV_MASK = {KEYS_W{1'b1}},
  parameter logic [LEDS_W-1:0]  LED_INV_MASK = {LEDS_W{1'b1}},
  parameter int                 DEB_CYCLES   = 500000,
  parameter int                 REP_DELAY    = 25000000,
  parameter int                 REP_PERIOD   = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS_W-1:0] keys_raw_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] press_o,
  output logic [KEYS_W-1:0] release_o,
  input  logic [LEDS_W-1:0] leds_i,
  output logic [LEDS_W-1:0] leds_o
);

  localparam int              CNT_W    = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("board_io_cond: DEB_CYCLES must be >= 1");
  end

  logic [KEYS_W-1:0]            w_pol;
  logic [KEYS_W-1:0]            w_stable_next;
  logic [KEYS_W-1:0]            w_rep_fire;
  logic [KEYS_W-1:0]            r_s1, r_s2, r_stable, r_prev;
  logic [KEYS_W-1:0]            r_press, r_release;
  logic [KEYS_W-1:0][CNT_W-1:0] r_cnt;
  logic [LEDS_W-1:0]            r_leds;

  // Normalise every key to active-high before it enters the synchroniser.
  assign w_pol = keys_raw_i ^ KEY_INV_MASK;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_stable_next = r_stable;
    for (int k = 0; k < KEYS_W; k++) begin
      if ((r_s2[k] != r_stable[k]) && (r_cnt[k] == DEB_LAST)) begin
        w_stable_next[k] = r_s2[k];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_stable  <= '0;
      r_prev    <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= w_pol;
      r_s2      <= r_s1;
      r_stable  <= w_stable_next;
      r_prev    <= r_stable;
      r_press   <= (r_stable & ~r_prev) | w_rep_fire;
      r_release <= ~r_stable & r_prev;
      for (int k = 0; k < KEYS_W; k++) begin
        // Any sample agreeing with the accepted level restarts the stability window.
        if ((r_s2[k] == r_stable[k]) || (r_cnt[k] == DEB_LAST)) begin
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_leds <= LED_INV_MASK;
    end else begin
      r_leds <= leds_i ^ LED_INV_MASK;
    end
  end

`ifdef BOARD_IO_AUTOREPEAT_EN
  localparam int               REP_MAX  = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int               REP_W    = (REP_MAX < 1) ? 1 : $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY  = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_PER  = REP_W'(REP_PERIOD);

  if (REP_PERIOD < 1) begin : g_bad_rep
    $error("board_io_cond: REP_PERIOD must be >= 1 when auto-repeat is enabled");
  end

  logic [KEYS_W-1:0][REP_W-1:0] r_rep_cnt;
  logic [KEYS_W-1:0]            r_rep_phase;

  // Phase 0 waits REP_DELAY after the initial press pulse, phase 1 counts REP_PERIOD.
  always_comb begin
    w_rep_fire = '0;
    for (int k = 0; k < KEYS_W; k++) begin
      if (r_stable[k] && w_stable_next[k] &&
          (r_rep_phase[k] ? (r_rep_cnt[k] == REP_PER) : (r_rep_cnt[k] == REP_DLY))) begin
        w_rep_fire[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= '0;
    end else begin
      for (int k = 0; k < KEYS_W; k++) begin
        if (!r_stable[k] || !w_stable_next[k]) begin
          r_rep_cnt[k]   <= '0;
          r_rep_phase[k] <= 1'b0;
        end else if (w_rep_fire[k]) begin
          r_rep_cnt[k]   <= REP_W'(1);
          r_rep_phase[k] <= 1'b1;
        end else begin
          r_rep_cnt[k]   <= r_rep_cnt[k] + REP_W'(1);
        end
      end
    end
  end
`else
  // Repeat timing has no effect in this build; only nonsensical values are flagged.
  if (REP_DELAY < 0 || REP_PERIOD < 0) begin : g_rep_ignored
    $info("board_io_cond: REP_DELAY/REP_PERIOD unused without auto-repeat");
  end

  assign w_rep_fire = '0;
`endif

  assign keys_o    = r_stable;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign leds_o    = r_leds;

endmodule

// File: tb/tb_board_io_cond.sv
// Self-checking bench for board_io_cond: two instances (DEB 4 / default masks, DEB 1 / custom
// masks) compared every cycle against a window-based behavioural model, plus directed literals.
module tb_board_io_cond;

  localparam int         REP_DELAY  = 10;
  localparam int         REP_PERIOD = 3;
`ifdef BOARD_IO_AUTOREPEAT_EN
  localparam bit         AUTOREP    = 1'b1;
`else
  localparam bit         AUTOREP    = 1'b0;
`endif
  localparam int         DEB_A      = 4;
  localparam int         DEB_B      = 1;
  localparam logic [3:0] KMASK_A    = 4'hF;
  localparam logic [3:0] KMASK_B    = 4'b0101;
  localparam logic [7:0] LMASK_A    = 8'hFF;
  localparam logic [7:0] LMASK_B    = 8'h0F;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pins_a, pins_b;
  logic [3:0] keys_a, press_a, rel_a, keys_b, press_b, rel_b;
  logic [7:0] ledi_a, ledi_b, ledo_a, ledo_b;

  always #5 clk = ~clk;

  board_io_cond #(
    .KEYS_W(4), .LEDS_W(8), .KEY_INV_MASK(KMASK_A), .LED_INV_MASK(LMASK_A),
    .DEB_CYCLES(DEB_A), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .keys_raw_i(pins_a), .keys_o(keys_a),
    .press_o(press_a), .release_o(rel_a), .leds_i(ledi_a), .leds_o(ledo_a)
  );

  board_io_cond #(
    .KEYS_W(4), .LEDS_W(8), .KEY_INV_MASK(KMASK_B), .LED_INV_MASK(LMASK_B),
    .DEB_CYCLES(DEB_B), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .keys_raw_i(pins_b), .keys_o(keys_b),
    .press_o(press_b), .release_o(rel_b), .leds_i(ledi_b), .leds_o(ledo_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A key level is accepted once the synchronised samples of the last DEB edges
  // all disagree with the current level; samples reach the logic two edges late.
  logic [3:0] ph     [2][16];
  logic [3:0] mkey   [2];
  logic [3:0] mprev  [2];
  logic [3:0] mpress [2];
  logic [3:0] mrel   [2];
  logic [7:0] mled   [2];
  int         held   [2][4];

  always @(posedge clk) begin : model
    logic [3:0] pol, nk;
    logic [7:0] li, lm;
    int         deb, age;
    bit         flip;
    for (int i = 0; i < 2; i++) begin
      pol = (i == 0) ? (pins_a ^ KMASK_A) : (pins_b ^ KMASK_B);
      li  = (i == 0) ? ledi_a : ledi_b;
      lm  = (i == 0) ? LMASK_A : LMASK_B;
      deb = (i == 0) ? DEB_A : DEB_B;
      if (rst) begin
        for (int k = 0; k < 16; k++) ph[i][k] = '0;
        mkey[i] = '0; mprev[i] = '0; mpress[i] = '0; mrel[i] = '0;
        mled[i] = lm;
        for (int c = 0; c < 4; c++) held[i][c] = 0;
      end else begin
        for (int k = 15; k > 0; k--) ph[i][k] = ph[i][k-1];
        ph[i][0] = pol;
        nk = mkey[i];
        for (int c = 0; c < 4; c++) begin
          flip = 1'b1;
          for (int k = 2; k < deb + 2; k++) if (ph[i][k][c] == mkey[i][c]) flip = 1'b0;
          if (flip) nk[c] = ~mkey[i][c];
        end
        mpress[i] = mkey[i] & ~mprev[i];
        mrel[i]   = ~mkey[i] & mprev[i];
        mprev[i]  = mkey[i];
        mkey[i]   = nk;
        for (int c = 0; c < 4; c++) begin
          held[i][c] = mkey[i][c] ? held[i][c] + 1 : 0;
          age = held[i][c] - 2;
          if (AUTOREP && mkey[i][c] && age >= REP_DELAY && ((age - REP_DELAY) % REP_PERIOD) == 0)
            mpress[i][c] = 1'b1;
        end
        mled[i] = li ^ lm;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("keys_a",  keys_a,  mkey[0]);
      check("press_a", press_a, mpress[0]);
      check("rel_a",   rel_a,   mrel[0]);
      check("leds_a",  ledo_a,  mled[0]);
      check("keys_b",  keys_b,  mkey[1]);
      check("press_b", press_b, mpress[1]);
      check("rel_b",   rel_b,   mrel[1]);
      check("leds_b",  ledo_b,  mled[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int t0, p0;
  int div;

  initial begin
    rst = 1'b1; pins_a = 4'hF; pins_b = 4'b0101; ledi_a = 8'hFF; ledi_b = 8'h00;

    // Reset values
    repeat (3) begin
      @(negedge clk);
      check("rst_keys",  keys_a,  4'h0);
      check("rst_press", press_a, 4'h0);
      check("rst_rel",   rel_a,   4'h0);
      check("rst_leds",  ledo_a,  8'hFF);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    check("leds_post_rst", ledo_a, 8'h00);

    // Clean press and release on key0
    #1 pins_a[0] = 1'b0; t0 = cyc;
    to_cycle(t0 + 5); check("press_keys_t5", keys_a[0], 1'b0);
    to_cycle(t0 + 6); check("press_keys_t6", keys_a[0], 1'b1);
    check("press_pulse_t6", press_a[0], 1'b0);
    to_cycle(t0 + 7); check("press_pulse_t7", press_a[0], 1'b1);
    to_cycle(t0 + 8); check("press_pulse_t8", press_a[0], 1'b0);
    #1 pins_a[0] = 1'b1; t0 = cyc;
    to_cycle(t0 + 6); check("rel_pulse_t6", rel_a[0], 1'b0);
    to_cycle(t0 + 7); check("rel_pulse_t7", rel_a[0], 1'b1);

    // Glitch rejection (3 cycles) then acceptance (4 cycles) on key1
    to_cycle(cyc + 3);
    #1 pins_a[1] = 1'b0; t0 = cyc;
    to_cycle(t0 + 3); #1 pins_a[1] = 1'b1;
    to_cycle(t0 + 15); check("glitch3_keys", keys_a[1], 1'b0);
    #1 pins_a[1] = 1'b0; t0 = cyc;
    to_cycle(t0 + 4); #1 pins_a[1] = 1'b1;
    to_cycle(t0 + 6);  check("glitch4_keys", keys_a[1], 1'b1);
    to_cycle(t0 + 7);  check("glitch4_press", press_a[1], 1'b1);
    to_cycle(t0 + 10); check("glitch4_drop", keys_a[1], 1'b0);
    to_cycle(t0 + 11); check("glitch4_rel", rel_a[1], 1'b1);

    // Simultaneous press on keys 0 and 3
    to_cycle(cyc + 3);
    #1 pins_a = 4'b0110; t0 = cyc;
    to_cycle(t0 + 7); check("multi_press", press_a, 4'b1001);
    to_cycle(t0 + 8); check("multi_press_end", press_a, 4'b0000);
    #1 pins_a = 4'hF;
    to_cycle(cyc + 10);

    // Reset two cycles into a debounce, key held through it
    #1 pins_a[2] = 1'b0; t0 = cyc;
    to_cycle(t0 + 4); #1 rst = 1'b1;
    to_cycle(t0 + 5); check("midrst_keys", keys_a, 4'h0);
    #1 rst = 1'b0; t0 = cyc;
    to_cycle(t0 + 6); check("midrst_press_t6", press_a[2], 1'b0);
    check("midrst_keys_t6", keys_a[2], 1'b1);
    to_cycle(t0 + 7); check("midrst_press_t7", press_a[2], 1'b1);
    #1 pins_a[2] = 1'b1;
    to_cycle(cyc + 10);

    // Polarity masks on instance b
    #1 pins_b = 4'b1010; t0 = cyc;
    to_cycle(t0 + 3); check("pol_keys", keys_b, 4'hF);
    check("pol_leds", ledo_b, 8'h0F);
    to_cycle(t0 + 4); check("pol_press", press_b, 4'hF);
    #1 pins_b = 4'b0101;
    to_cycle(cyc + 6);

    // Auto-repeat on key2 of instance b (DEB 1)
    #1 pins_b[2] = 1'b0; t0 = cyc; p0 = t0 + 4;
    to_cycle(p0);      check("rep_p0",  press_b[2], 1'b1);
    to_cycle(p0 + 1);  check("rep_p1",  press_b[2], 1'b0);
    to_cycle(p0 + 10); check("rep_p10", press_b[2], AUTOREP);
    to_cycle(p0 + 11); check("rep_p11", press_b[2], 1'b0);
    to_cycle(p0 + 13); check("rep_p13", press_b[2], AUTOREP);
    to_cycle(p0 + 16); check("rep_p16", press_b[2], AUTOREP);
    to_cycle(p0 + 19); check("rep_p19", press_b[2], AUTOREP);
    #1 pins_b[2] = 1'b1;
    to_cycle(p0 + 22); check("rep_p22", press_b[2], 1'b0);
    to_cycle(p0 + 23); check("rep_rel", rel_b[2], 1'b1);
    to_cycle(cyc + 6);

    // Randomised phase: bursty pin activity, random LEDs, occasional reset
    div = 6;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       div = 3;
          1:       div = 8;
          default: div = 30;
        endcase
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, div - 1) == 0) pins_a[c] = ~pins_a[c];
        if ($urandom_range(0, div - 1) == 0) pins_b[c] = ~pins_b[c];
      end
      ledi_a = 8'($urandom);
      ledi_b = 8'($urandom);
      rst    = ($urandom_range(0, 299) == 0);
    end
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
